map_tile_store: RTL and testbench
=================================

# map_tile_store

Tile-map storage that answers the map renderer's grid scan. It returns the tile index for the currently addressed grid cell with zero latency, so the renderer can fetch the tile bitmap. It also accepts single-cell writes and two-cell swaps from game logic over a req/ack handshake. An init sequencer fills the map with a default layout after reset or on request.

## Interface
- MAP_WIDTH, 13: columns, 1..16
- MAP_HEIGHT, 13: rows, 1..16
- TILE_W, 19: tile index width
- FLOOR_TILE, 0: fill value written by init
- WALL_TILE, 1: border value written by init (MAP_BORDER_EN only)
- map_clk  in  1  clock; tile-advance clock of the map renderer
- rstn  in  1  reset, asynchronous, active-low
- grid_x  in  4  renderer scan column
- grid_y  in  4  renderer scan row
- tile_id  out  TILE_W  tile index at (grid_x, grid_y)
- ready  out  1  high when idle and init complete
- init_req  in  1  restart init sequence
- wr_req  in  1  write/swap request, held until wr_ack
- wr_op  in  1  0 = write wr_tile to A, 1 = swap A and B
- wr_x, wr_y  in  4 each  cell A
- wr_x2, wr_y2  in  4 each  cell B (swap only)
- wr_tile  in  TILE_W  write data
- wr_ack  out  1  one-cycle completion pulse
- wr_err  out  1  valid with wr_ack; request rejected (coordinate out of range)

## Operation
- Storage: MAP_WIDTH*MAP_HEIGHT registers of TILE_W bits, index = y*MAP_WIDTH + x. Cells are not reset; init overwrites them.
- Read path is combinational from grid_x/grid_y and storage:
  - grid_x >= MAP_WIDTH or grid_y >= MAP_HEIGHT -> tile_id = 0.
  - State INIT -> tile_id = FLOOR_TILE.
  - Otherwise tile_id = the cell contents, including a write made at the preceding edge.
- FSM states: INIT, IDLE, SWAP2.
  - INIT: init counter walks index 0..W*H-1, one cell per edge. Each cell gets WALL_TILE if it is a border cell (x=0, y=0, x=W-1, y=H-1) and MAP_BORDER_EN is defined, else FLOOR_TILE. After the last cell -> IDLE.
  - IDLE, init_req=1: counter := 0 -> INIT. init_req has priority over a simultaneous wr_req, which stays pending.
  - IDLE, wr_req=1, any coordinate out of range: no storage change; wr_ack=1, wr_err=1 next cycle. Range is checked on A only for op 0, on A and B for op 1.
  - IDLE, wr_req=1, op 0: cell[A] := wr_tile; wr_ack next cycle.
  - IDLE, wr_req=1, op 1: tmp := cell[A]; cell[A] := cell[B] -> SWAP2.
  - SWAP2: cell[B] := tmp; wr_ack next cycle -> IDLE. init_req is ignored here and honoured from IDLE afterwards.
  - Swap with A == B leaves the cell unchanged and still acks.
- Handshake:
  - Requester holds wr_req and all wr_* fields stable until it sees wr_ack, then drops wr_req in the cycle after.
  - A request is not accepted in the cycle wr_ack is high.
  - wr_req is ignored in INIT and stays pending.
- ready = (state == IDLE) and not wr_ack.

## Timing
- Reset values: state INIT, counter 0, ready 0, wr_ack 0, wr_err 0, tile_id = FLOOR_TILE for in-range grid.
- Init length is W*H edges after rstn deassert; ready rises at the edge that writes the last cell. Default 169 cycles.
- Write latency: accept at edge N, data visible to tile_id after edge N, wr_ack high during cycle N..N+1.
- Swap latency: accept at edge N, B updated at N+1, wr_ack high during cycle N+1..N+2.
- Reset asserted mid-init or mid-swap aborts immediately: the swap may be half-done, and the full init reruns.
- wr_err is 0 whenever wr_ack is 0.

## Configuration
- MAP_BORDER_EN defined: init writes WALL_TILE on the perimeter and FLOOR_TILE inside.
- MAP_BORDER_EN not defined: init writes FLOOR_TILE everywhere, and WALL_TILE is unused.

## Test plan
- Reset, then count cycles:
  - ready rises after exactly 169 map_clk edges.
  - With MAP_BORDER_EN, (0,0) reads 1 and (6,6) reads 0.
  - Without it, both read 0.
- Write op 0 (3,4), tile 0x1A5 -> wr_ack one cycle, wr_err 0, (3,4) reads 0x1A5, neighbours unchanged.
- Swap (3,4)=0x1A5 with (5,5)=0x022 -> ack two cycles after accept, (3,4)=0x022, (5,5)=0x1A5; swap (2,2) with itself leaves it unchanged.
- Write to (13,0) -> wr_ack with wr_err 1, no cell changed; grid read of (14,2) returns 0.
- init_req and wr_req in the same IDLE cycle -> init runs first and tile_id reads FLOOR_TILE throughout; the pending write is acked after ready returns, and its cell reads the new value.
- rstn pulse during the SWAP2 cycle -> ready 0, full 169-cycle reinit, wr_ack never pulses for the aborted swap.

Source files
------------

// File: rtl/map_tile_store.sv
// Tile-map storage: zero-latency grid read for the renderer, req/ack write/swap port, init fill sequencer.
// Define MAP_BORDER_EN to have init paint WALL_TILE around the map perimeter.
module map_tile_store #(
    parameter int                MAP_WIDTH  = 13,
    parameter int                MAP_HEIGHT = 13,
    parameter int                TILE_W     = 19,
    parameter logic [TILE_W-1:0] FLOOR_TILE = TILE_W'(1'b0),
    parameter logic [TILE_W-1:0] WALL_TILE  = TILE_W'(1'b1)
) (
    input  logic              map_clk,
    input  logic              rstn,
    input  logic [3:0]        grid_x,
    input  logic [3:0]        grid_y,
    output logic [TILE_W-1:0] tile_id,
    output logic              ready,
    input  logic              init_req,
    input  logic              wr_req,
    input  logic              wr_op,
    input  logic [3:0]        wr_x,
    input  logic [3:0]        wr_y,
    input  logic [3:0]        wr_x2,
    input  logic [3:0]        wr_y2,
    input  logic [TILE_W-1:0] wr_tile,
    output logic              wr_ack,
    output logic              wr_err
);
    localparam int         N_CELLS = MAP_WIDTH * MAP_HEIGHT;
    localparam int         IDX_W   = 8;
    localparam logic [4:0] W_LIM   = 5'(MAP_WIDTH);
    localparam logic [4:0] H_LIM   = 5'(MAP_HEIGHT);
    localparam logic [3:0] X_LAST  = 4'(MAP_WIDTH - 1);
    localparam logic [3:0] Y_LAST  = 4'(MAP_HEIGHT - 1);
`ifdef MAP_BORDER_EN
    localparam logic BORDER_EN = 1'b1;
`else
    localparam logic BORDER_EN = 1'b0;
`endif

    typedef enum logic [1:0] {ST_INIT = 2'd0, ST_IDLE = 2'd1, ST_SWAP2 = 2'd2} state_t;

    function automatic logic [IDX_W-1:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
        return IDX_W'(y) * IDX_W'(MAP_WIDTH) + IDX_W'(x);
    endfunction

    function automatic logic in_range(input logic [3:0] x, input logic [3:0] y);
        return ({1'b0, x} < W_LIM) && ({1'b0, y} < H_LIM);
    endfunction

    logic [TILE_W-1:0] cells_r [N_CELLS];
    state_t            state_r, state_nxt_s;
    logic [3:0]        init_x_r, init_y_r, init_x_nxt_s, init_y_nxt_s;
    logic [TILE_W-1:0] tmp_r, tmp_nxt_s;
    logic [IDX_W-1:0]  swp_idx_r, swp_idx_nxt_s;
    logic              wr_ack_r, wr_err_r, ready_r, ack_nxt_s, err_nxt_s;
    logic              we_s;
    logic [IDX_W-1:0]  waddr_s;
    logic [TILE_W-1:0] wdata_s;

    logic              a_ok_s, b_ok_s, g_ok_s, border_s;
    logic [IDX_W-1:0]  a_idx_s, b_idx_s, g_idx_s, init_idx_s;
    logic [TILE_W-1:0] a_data_s, b_data_s, init_fill_s;

    assign a_ok_s      = in_range(wr_x, wr_y);
    assign b_ok_s      = in_range(wr_x2, wr_y2);
    assign g_ok_s      = in_range(grid_x, grid_y);
    assign a_idx_s     = cell_idx(wr_x, wr_y);
    assign b_idx_s     = cell_idx(wr_x2, wr_y2);
    assign g_idx_s     = cell_idx(grid_x, grid_y);
    assign init_idx_s  = cell_idx(init_x_r, init_y_r);
    assign a_data_s    = a_ok_s ? cells_r[a_idx_s] : TILE_W'(1'b0);
    assign b_data_s    = b_ok_s ? cells_r[b_idx_s] : TILE_W'(1'b0);
    assign border_s    = (init_x_r == 4'd0) || (init_y_r == 4'd0) ||
                         (init_x_r == X_LAST) || (init_y_r == Y_LAST);
    assign init_fill_s = (BORDER_EN && border_s) ? WALL_TILE : FLOOR_TILE;

    assign wr_ack = wr_ack_r;
    assign wr_err = wr_err_r;
    assign ready  = ready_r;

    // Renderer read path; INIT masks the partially filled storage.
    always_comb begin
        tile_id = TILE_W'(1'b0);
        if (!g_ok_s) begin
            tile_id = TILE_W'(1'b0);
        end else if (state_r == ST_INIT) begin
            tile_id = FLOOR_TILE;
        end else begin
            tile_id = cells_r[g_idx_s];
        end
    end

    // Next-state, single storage write port and handshake outputs.
    always_comb begin
        state_nxt_s   = state_r;
        init_x_nxt_s  = init_x_r;
        init_y_nxt_s  = init_y_r;
        tmp_nxt_s     = tmp_r;
        swp_idx_nxt_s = swp_idx_r;
        ack_nxt_s     = 1'b0;
        err_nxt_s     = 1'b0;
        we_s          = 1'b0;
        waddr_s       = init_idx_s;
        wdata_s       = init_fill_s;
        case (state_r)
            ST_INIT: begin
                we_s = 1'b1;
                if (init_x_r == X_LAST) begin
                    init_x_nxt_s = 4'd0;
                    if (init_y_r == Y_LAST) begin
                        init_y_nxt_s = 4'd0;
                        state_nxt_s  = ST_IDLE;
                    end else begin
                        init_y_nxt_s = init_y_r + 4'd1;
                    end
                end else begin
                    init_x_nxt_s = init_x_r + 4'd1;
                end
            end
            ST_IDLE: begin
                if (init_req) begin
                    init_x_nxt_s = 4'd0;
                    init_y_nxt_s = 4'd0;
                    state_nxt_s  = ST_INIT;
                end else if (wr_req && !wr_ack_r) begin
                    if (!a_ok_s || (wr_op && !b_ok_s)) begin
                        ack_nxt_s = 1'b1;
                        err_nxt_s = 1'b1;
                    end else if (!wr_op) begin
                        we_s      = 1'b1;
                        waddr_s   = a_idx_s;
                        wdata_s   = wr_tile;
                        ack_nxt_s = 1'b1;
                    end else begin
                        // First half of the swap; B's address is captured so SWAP2 is self-contained.
                        we_s          = 1'b1;
                        waddr_s       = a_idx_s;
                        wdata_s       = b_data_s;
                        tmp_nxt_s     = a_data_s;
                        swp_idx_nxt_s = b_idx_s;
                        state_nxt_s   = ST_SWAP2;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SWAP2: begin
                we_s        = 1'b1;
                waddr_s     = swp_idx_r;
                wdata_s     = tmp_r;
                ack_nxt_s   = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                init_x_nxt_s = 4'd0;
                init_y_nxt_s = 4'd0;
                state_nxt_s  = ST_INIT;
            end
        endcase
    end

    // Control state and registered handshake outputs.
    always_ff @(posedge map_clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= ST_INIT;
            init_x_r  <= 4'd0;
            init_y_r  <= 4'd0;
            tmp_r     <= TILE_W'(1'b0);
            swp_idx_r <= IDX_W'(1'b0);
            wr_ack_r  <= 1'b0;
            wr_err_r  <= 1'b0;
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            init_x_r  <= init_x_nxt_s;
            init_y_r  <= init_y_nxt_s;
            tmp_r     <= tmp_nxt_s;
            swp_idx_r <= swp_idx_nxt_s;
            wr_ack_r  <= ack_nxt_s;
            wr_err_r  <= err_nxt_s;
            ready_r   <= (state_nxt_s == ST_IDLE) && !ack_nxt_s;
        end
    end

    // Map storage; intentionally not reset, init overwrites every cell.
    always_ff @(posedge map_clk) begin
        if (we_s) begin
            cells_r[waddr_s] <= wdata_s;
        end
    end
endmodule

// File: tb/tb_map_tile_store.sv
// Directed bench for map_tile_store: init timing, writes, swaps, range errors, init/write priority, reset mid-swap.
module tb_map_tile_store;
    localparam int W  = 13;
    localparam int H  = 13;
    localparam int TW = 19;
    localparam int N  = W * H;

    logic          map_clk = 1'b0;
    logic          rstn;
    logic [3:0]    grid_x, grid_y, wr_x, wr_y, wr_x2, wr_y2;
    logic [TW-1:0] tile_id, wr_tile;
    logic          ready, init_req, wr_req, wr_op, wr_ack, wr_err;

    int total = 0;
    int bad   = 0;
    logic [TW-1:0] mdl [N];

    typedef struct {
        string tag;
        logic  err;
        int    lat;
    } exp_t;
    exp_t sb[$];

    map_tile_store dut (
        .map_clk (map_clk),
        .rstn    (rstn),
        .grid_x  (grid_x),
        .grid_y  (grid_y),
        .tile_id (tile_id),
        .ready   (ready),
        .init_req(init_req),
        .wr_req  (wr_req),
        .wr_op   (wr_op),
        .wr_x    (wr_x),
        .wr_y    (wr_y),
        .wr_x2   (wr_x2),
        .wr_y2   (wr_y2),
        .wr_tile (wr_tile),
        .wr_ack  (wr_ack),
        .wr_err  (wr_err)
    );

    always #5 map_clk = ~map_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_init();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
`ifdef MAP_BORDER_EN
                mdl[y*W+x] = (x == 0 || y == 0 || x == W-1 || y == H-1) ? 19'd1 : 19'd0;
`else
                mdl[y*W+x] = 19'd0;
`endif
            end
        end
    endtask

    task automatic chk_map(input string tag);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                grid_x = 4'(x);
                grid_y = 4'(y);
                #1;
                chk($sformatf("%s_%0d_%0d", tag, x, y), 32'(tile_id), 32'(mdl[y*W+x]));
            end
        end
        @(negedge map_clk);
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        int floor_bad = 0;
        int acks = 0;
        grid_x = 4'd0;
        grid_y = 4'd0;
        while (!ready && n < 400) begin
            @(posedge map_clk);
            #1;
            n++;
            if (!ready && tile_id !== 19'd0) floor_bad++;
            if (wr_ack) acks++;
        end
        chk({tag, "_len"}, 32'(n), 32'd169);
        chk({tag, "_floor"}, 32'(floor_bad), 32'd0);
        chk({tag, "_noack"}, 32'(acks), 32'd0);
        @(negedge map_clk);
    endtask

    task automatic do_req(input string tag, input logic op, input int x, input int y,
                          input int x2, input int y2, input logic [TW-1:0] t,
                          input logic exp_err, input int exp_lat, input bit with_init);
        exp_t e;
        int n = 0;
        int floor_bad = 0;
        int rdy_at = 0;
        bit seen = 1'b0;
        e.tag = tag;
        e.err = exp_err;
        e.lat = exp_lat;
        sb.push_back(e);
        @(negedge map_clk);
        wr_op = op; wr_x = 4'(x); wr_y = 4'(y); wr_x2 = 4'(x2); wr_y2 = 4'(y2);
        wr_tile = t; wr_req = 1'b1; init_req = with_init;
        grid_x = 4'(x); grid_y = 4'(y);
        while (!seen && n < 400) begin
            @(posedge map_clk);
            #1;
            n++;
            init_req = 1'b0;
            if (ready && rdy_at == 0) rdy_at = n;
            if (wr_ack) begin
                seen = 1'b1;
            end else if (with_init && !ready && tile_id !== 19'd0) begin
                floor_bad++;
            end
        end
        wr_req = 1'b0;
        e = sb.pop_front();
        if (!seen) begin
            chk({e.tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({e.tag, "_err"}, 32'(wr_err), 32'(e.err));
            chk({e.tag, "_lat"}, 32'(n), 32'(e.lat));
            if (!op && !exp_err) chk({e.tag, "_visible"}, 32'(tile_id), 32'(t));
        end
        if (with_init) begin
            chk({tag, "_rdy_at"}, 32'(rdy_at), 32'd170);
            chk({tag, "_floor"}, 32'(floor_bad), 32'd0);
        end
        @(posedge map_clk);
        #1;
        chk({tag, "_ackpulse"}, 32'(wr_ack), 32'd0);
        chk({tag, "_errlow"}, 32'(wr_err), 32'd0);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        @(negedge map_clk);
    endtask

    initial begin
        logic [TW-1:0] t;
        rstn = 1'b0; init_req = 1'b0; wr_req = 1'b0; wr_op = 1'b0;
        wr_x = 4'd0; wr_y = 4'd0; wr_x2 = 4'd0; wr_y2 = 4'd0; wr_tile = 19'd0;
        grid_x = 4'd0; grid_y = 4'd0;
        #12;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_ack", 32'(wr_ack), 32'd0);
        chk("rst_err", 32'(wr_err), 32'd0);
        chk("rst_tile", 32'(tile_id), 32'd0);
        @(negedge map_clk);
        rstn = 1'b1;
        wait_init("init");
        mdl_init();
        chk_map("map_init");

        do_req("wr34", 1'b0, 3, 4, 0, 0, 19'h1A5, 1'b0, 1, 1'b0);
        mdl[4*W+3] = 19'h1A5;
        do_req("wr55", 1'b0, 5, 5, 0, 0, 19'h022, 1'b0, 1, 1'b0);
        mdl[5*W+5] = 19'h022;
        chk_map("map_wr");

        do_req("swap", 1'b1, 3, 4, 5, 5, 19'h0, 1'b0, 2, 1'b0);
        t = mdl[4*W+3]; mdl[4*W+3] = mdl[5*W+5]; mdl[5*W+5] = t;
        do_req("swap_self", 1'b1, 2, 2, 2, 2, 19'h0, 1'b0, 2, 1'b0);
        chk_map("map_swap");

        do_req("wr_oob", 1'b0, 13, 0, 0, 0, 19'h7, 1'b1, 1, 1'b0);
        do_req("swap_oob", 1'b1, 1, 1, 0, 13, 19'h0, 1'b1, 1, 1'b0);
        do_req("wr_b_ignored", 1'b0, 6, 6, 15, 15, 19'h55, 1'b0, 1, 1'b0);
        mdl[6*W+6] = 19'h55;
        chk_map("map_oob");
        grid_x = 4'd14; grid_y = 4'd2;
        #1;
        chk("grid_oob_x", 32'(tile_id), 32'd0);
        grid_x = 4'd2; grid_y = 4'd13;
        #1;
        chk("grid_oob_y", 32'(tile_id), 32'd0);
        @(negedge map_clk);

        do_req("init_wr", 1'b0, 7, 7, 0, 0, 19'h3FF, 1'b0, 171, 1'b1);
        mdl_init();
        mdl[7*W+7] = 19'h3FF;
        chk_map("map_initwr");

        wr_op = 1'b1; wr_x = 4'd1; wr_y = 4'd1; wr_x2 = 4'd2; wr_y2 = 4'd3; wr_req = 1'b1;
        @(posedge map_clk);
        #1;
        chk("swap2_busy", 32'(ready), 32'd0);
        rstn = 1'b0;
        #1;
        chk("rst_mid_ready", 32'(ready), 32'd0);
        chk("rst_mid_ack", 32'(wr_ack), 32'd0);
        wr_req = 1'b0;
        @(negedge map_clk);
        rstn = 1'b1;
        wait_init("reinit");
        mdl_init();
        chk_map("map_reinit");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
